// File: rtl/ni_pkt_sender_if.sv
// ni_pkt_sender_if: per-channel PE flit inputs plus the shared network link of the packet sender.
interface ni_pkt_sender_if #(parameter int NCH = 2, parameter int DW = 16);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   logic [NCH-1:0]    valid_i;
   logic [NCH*DW-1:0] data_i;
   logic [NCH-1:0]    ready_o;
   logic              valid_o;
   logic [DW-1:0]     data_o;
   logic [CHW-1:0]    ch_o;
   logic              ready_i;
   logic              credit_upd_i;
   logic              err_o;
   modport slave (input valid_i, data_i, ready_i, credit_upd_i, output ready_o, valid_o, data_o, ch_o, err_o);
   modport master (output valid_i, data_i, ready_i, credit_upd_i, input ready_o, valid_o, data_o, ch_o, err_o);
endinterface

// File: rtl/ni_pkt_sender.sv
// ni_pkt_sender: packet-atomic round-robin merge of NCH buffered flit channels onto one credited link.
module ni_pkt_sender #(
   parameter int         NCH        = 2,
   parameter int         DW         = 16,
   parameter int         PKT_LEN    = 4,
   parameter int         BUF_DEPTH  = 8,
   parameter int         CREDITS    = 4,
   parameter int         PKT_ATOMIC = 1,
   parameter logic [1:0] HEAD       = 2'b10,
   parameter logic [1:0] TAIL       = 2'b01
) (
   input logic            clk,
   input logic            rstn,
   ni_pkt_sender_if.slave bus
);
   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int AW  = $clog2(BUF_DEPTH);
   localparam int NW  = $clog2(BUF_DEPTH + 1);
   localparam int CW  = $clog2(CREDITS + 1);
   typedef enum logic {IDLE, SEND} state_t;
   state_t          r_state, w_state_nxt;
   logic [CHW-1:0]  r_ch, r_last, w_gnt;
   logic [CW-1:0]   r_credit;
   logic            r_err;
   logic [NCH-1:0]  w_wr, w_rd, w_empty, w_elig, w_bad;
   logic [DW-1:0]   w_head [NCH];
   logic            w_any, w_hs, w_tail, w_cerr;
   for (genvar k = 0; k < NCH; k++) begin : g_ch
      logic [DW-1:0] r_mem [BUF_DEPTH];
      logic [AW-1:0] r_wp, r_rp;
      logic [NW-1:0] r_cnt;
      logic          w_full, w_typ_ok, w_len_ok;
      assign w_full         = r_cnt == NW'(BUF_DEPTH);
      assign w_empty[k]     = r_cnt == '0;
      assign bus.ready_o[k] = ~w_full;
      assign w_wr[k]        = bus.valid_i[k] & ~w_full;
      assign w_rd[k]        = w_hs & (r_ch == CHW'(k));
      assign w_head[k]      = r_mem[r_rp];
      assign w_len_ok       = (PKT_ATOMIC != 0) ? (r_cnt >= NW'(PKT_LEN)) : ~w_empty[k];
      assign w_typ_ok       = w_head[k][DW-1 -: 2] == HEAD;
      assign w_elig[k]      = w_len_ok & w_typ_ok;
      // a stray non-head flit is never drained, so its channel stays blocked until reset
      assign w_bad[k]       = w_len_ok & ~w_typ_ok & ~w_empty[k] & ((r_state == IDLE) | (r_ch != CHW'(k)));
      always_ff @(posedge clk)
         if (w_wr[k]) r_mem[r_wp] <= bus.data_i[k*DW +: DW];
      always_ff @(posedge clk or negedge rstn)
         if (!rstn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
         end else begin
            if (w_wr[k]) r_wp <= r_wp + 1'b1;
            if (w_rd[k]) r_rp <= r_rp + 1'b1;
            if (w_wr[k] != w_rd[k]) r_cnt <= w_wr[k] ? r_cnt + 1'b1 : r_cnt - 1'b1;
         end
   end
   // search from last_grant+1; scanning downward lets the nearest eligible channel win
   always_comb begin
      int j;
      w_any = 1'b0;
      w_gnt = r_last;
      for (int i = NCH; i >= 1; i--) begin
         j = (int'(r_last) + i) % NCH;
         if (w_elig[j[CHW-1:0]]) begin
            w_any = 1'b1;
            w_gnt = j[CHW-1:0];
         end
      end
   end
   assign bus.valid_o = (r_state == SEND) & ~w_empty[r_ch] & (r_credit != '0);
   assign bus.data_o  = bus.valid_o ? w_head[r_ch] : '0;
   assign bus.ch_o    = r_ch;
   assign bus.err_o   = r_err;
   assign w_hs        = bus.valid_o & bus.ready_i;
   assign w_tail      = w_head[r_ch][DW-1 -: 2] == TAIL;
   assign w_cerr      = bus.credit_upd_i & ~w_hs & (r_credit == CW'(CREDITS));
   always_comb begin
      w_state_nxt = r_state;
      w_state_nxt = (r_state == IDLE) ? (w_any ? SEND : IDLE) : ((w_hs & w_tail) ? IDLE : SEND);
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         r_state  <= IDLE;
         r_ch     <= '0;
         r_last   <= CHW'(NCH - 1);
         r_credit <= CW'(CREDITS);
         r_err    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_any) begin
            r_ch   <= w_gnt;
            r_last <= w_gnt;
         end
         if (w_hs != bus.credit_upd_i) r_credit <= w_hs ? r_credit - 1'b1 : (w_cerr ? r_credit : r_credit + 1'b1);
         r_err <= r_err | (|w_bad) | w_cerr;
      end
endmodule

// File: tb/tb_ni_pkt_sender.sv
// tb_ni_pkt_sender: directed checks of three sender variants (4 credits, 2 credits, cut-through) fed identical stimulus.
module tb_ni_pkt_sender;
   localparam logic [1:0] H = 2'b10, B = 2'b00, T = 2'b01;
   logic clk = 1'b0, rstn = 1'b0;
   int   vectors = 0, miscompares = 0;
   ni_pkt_sender_if #(.NCH(2), .DW(16)) b0 (), b1 (), b2 ();
   always #5 clk = ~clk;
   assign b1.valid_i = b0.valid_i;
   assign b1.data_i = b0.data_i;
   assign b1.ready_i = b0.ready_i;
   assign b1.credit_upd_i = b0.credit_upd_i;
   assign b2.valid_i = b0.valid_i;
   assign b2.data_i = b0.data_i;
   assign b2.ready_i = b0.ready_i;
   assign b2.credit_upd_i = b0.credit_upd_i;
   ni_pkt_sender #(.NCH(2), .DW(16), .PKT_LEN(4), .BUF_DEPTH(8), .CREDITS(4), .PKT_ATOMIC(1)) u0 (.clk(clk), .rstn(rstn), .bus(b0));
   ni_pkt_sender #(.NCH(2), .DW(16), .PKT_LEN(4), .BUF_DEPTH(8), .CREDITS(2), .PKT_ATOMIC(1)) u1 (.clk(clk), .rstn(rstn), .bus(b1));
   ni_pkt_sender #(.NCH(2), .DW(16), .PKT_LEN(4), .BUF_DEPTH(8), .CREDITS(4), .PKT_ATOMIC(0)) u2 (.clk(clk), .rstn(rstn), .bus(b2));
   function automatic logic [15:0] fl(logic [1:0] t, int ch, int pkt, int idx);
      return {t, 2'b00, 4'(ch), 4'(pkt), 4'(idx)};
   endfunction
   function automatic logic [1:0] ty(int idx);
      return (idx == 0) ? H : (idx == 3) ? T : B;
   endfunction
   task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wr(logic [1:0] v, logic [15:0] f0, logic [15:0] f1);
      b0.valid_i = v;
      b0.data_i = {f1, f0};
      step();
      b0.valid_i = '0;
   endtask
   task automatic do_reset();
      b0.valid_i = '0;
      b0.data_i = '0;
      b0.ready_i = 1'b0;
      b0.credit_upd_i = 1'b0;
      rstn = 1'b0;
      step();
      step();
      rstn = 1'b1;
   endtask
   initial begin
      b0.valid_i = '0;
      b0.data_i = '0;
      b0.ready_i = 1'b0;
      b0.credit_upd_i = 1'b0;
      step();
      chk("rst_valid", b0.valid_o, 0);
      chk("rst_data", b0.data_o, 0);
      chk("rst_ch", b0.ch_o, 0);
      chk("rst_ready", b0.ready_o, 2'b11);
      chk("rst_err", b0.err_o, 0);
      // single packet on u0, credit stall on u1
      do_reset();
      b0.ready_i = 1'b1;
      for (int i = 0; i < 4; i++) wr(2'b01, fl(ty(i), 0, 0, i), '0);
      chk("sp_c4_valid", b0.valid_o, 0);
      step();
      for (int i = 0; i < 4; i++) begin
         chk("sp_valid", b0.valid_o, 1);
         chk("sp_data", b0.data_o, fl(ty(i), 0, 0, i));
         chk("sp_ch", b0.ch_o, 0);
         chk("cs_valid", b1.valid_o, (i < 2) ? 1 : 0);
         if (i < 2) chk("cs_data", b1.data_o, fl(ty(i), 0, 0, i));
         step();
      end
      chk("sp_after", b0.valid_o, 0);
      chk("cs_c9", b1.valid_o, 0);
      step();
      chk("cs_c10", b1.valid_o, 0);
      b0.credit_upd_i = 1'b1;
      step();
      chk("cs_c11_valid", b1.valid_o, 1);
      chk("cs_c11_data", b1.data_o, fl(B, 0, 0, 2));
      step();
      b0.credit_upd_i = 1'b0;
      chk("cs_c12_valid", b1.valid_o, 1);
      chk("cs_c12_data", b1.data_o, fl(T, 0, 0, 3));
      step();
      chk("cs_c13", b1.valid_o, 0);
      // round robin with a full buffer on ch0
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("rr_ready7", b0.ready_o, 2'b11);
         wr(2'b11, fl(ty(i % 4), 0, i / 4, i % 4), fl(ty(i % 4), 1, i / 4, i % 4));
      end
      chk("rr_full", b0.ready_o, 2'b00);
      b0.ready_i = 1'b1;
      for (int j = 0; j < 19; j++) begin
         chk("rr_valid", b0.valid_o, (j % 5 != 4) ? 1 : 0);
         if (j % 5 != 4) begin
            chk("rr_ch", b0.ch_o, (j / 5) % 2);
            chk("rr_data", b0.data_o, fl(ty(j % 5), (j / 5) % 2, j / 10, j % 5));
         end
         b0.credit_upd_i = (j % 5 != 4);
         step();
      end
      b0.credit_upd_i = 1'b0;
      chk("rr_end_valid", b0.valid_o, 0);
      chk("rr_end_err", b0.err_o, 0);
      // backpressure mid-packet
      do_reset();
      b0.ready_i = 1'b1;
      for (int i = 0; i < 4; i++) wr(2'b01, fl(ty(i), 0, 2, i), '0);
      step();
      chk("bp_head", b0.data_o, fl(H, 0, 2, 0));
      step();
      b0.ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("bp_hold_valid", b0.valid_o, 1);
         chk("bp_hold_data", b0.data_o, fl(B, 0, 2, 1));
         step();
      end
      b0.ready_i = 1'b1;
      chk("bp_b1", b0.data_o, fl(B, 0, 2, 1));
      step();
      chk("bp_b2", b0.data_o, fl(B, 0, 2, 2));
      step();
      chk("bp_tail", b0.data_o, fl(T, 0, 2, 3));
      step();
      chk("bp_done", b0.valid_o, 0);
      // cut-through on u2
      do_reset();
      b0.ready_i = 1'b1;
      wr(2'b01, fl(H, 0, 3, 0), '0);
      chk("ct_c1", b2.valid_o, 0);
      step();
      chk("ct_head_valid", b2.valid_o, 1);
      chk("ct_head_data", b2.data_o, fl(H, 0, 3, 0));
      step();
      chk("ct_empty", b2.valid_o, 0);
      wr(2'b11, fl(B, 0, 3, 1), fl(H, 1, 3, 0));
      chk("ct_body", b2.data_o, fl(B, 0, 3, 1));
      chk("ct_body_ch", b2.ch_o, 0);
      step();
      chk("ct_gap_valid", b2.valid_o, 0);
      chk("ct_gap_ch", b2.ch_o, 0);
      wr(2'b01, fl(T, 0, 3, 2), '0);
      chk("ct_tail", b2.data_o, fl(T, 0, 3, 2));
      chk("ct_tail_ch", b2.ch_o, 0);
      step();
      chk("ct_bubble", b2.valid_o, 0);
      step();
      chk("ct_ch1_data", b2.data_o, fl(H, 1, 3, 0));
      chk("ct_ch1_ch", b2.ch_o, 1);
      // malformed head on ch0, good packet on ch1
      do_reset();
      b0.ready_i = 1'b1;
      wr(2'b11, fl(B, 0, 4, 0), fl(H, 1, 4, 0));
      wr(2'b11, fl(B, 0, 4, 1), fl(B, 1, 4, 1));
      chk("er_ct_err", b2.err_o, 1);
      chk("er_early", b0.err_o, 0);
      wr(2'b11, fl(B, 0, 4, 2), fl(B, 1, 4, 2));
      wr(2'b11, fl(B, 0, 4, 3), fl(T, 1, 4, 3));
      chk("er_c4_err", b0.err_o, 0);
      chk("er_c4_valid", b0.valid_o, 0);
      step();
      chk("er_err", b0.err_o, 1);
      for (int i = 0; i < 4; i++) begin
         chk("er_ch", b0.ch_o, 1);
         chk("er_data", b0.data_o, fl(ty(i), 1, 4, i));
         step();
      end
      chk("er_c9", b0.valid_o, 0);
      step();
      chk("er_blocked", b0.valid_o, 0);
      // credit overflow, then reset mid-packet
      do_reset();
      b0.ready_i = 1'b1;
      b0.credit_upd_i = 1'b1;
      wr(2'b01, fl(H, 0, 5, 0), '0);
      b0.credit_upd_i = 1'b0;
      chk("co_err", b0.err_o, 1);
      for (int i = 1; i < 8; i++) wr(2'b01, fl(ty(i % 4), 0, 5 + i / 4, i % 4), '0);
      chk("co_tail", b0.data_o, fl(T, 0, 5, 3));
      step();
      chk("co_bubble", b0.valid_o, 0);
      step();
      chk("co_nocredit", b0.valid_o, 0);
      step();
      chk("co_nocredit2", b0.valid_o, 0);
      b0.credit_upd_i = 1'b1;
      step();
      b0.credit_upd_i = 1'b0;
      chk("co_resume", b0.data_o, fl(H, 0, 6, 0));
      rstn = 1'b0;
      #1;
      chk("mr_valid", b0.valid_o, 0);
      chk("mr_data", b0.data_o, 0);
      chk("mr_ch", b0.ch_o, 0);
      chk("mr_ready", b0.ready_o, 2'b11);
      chk("mr_err", b0.err_o, 0);
      step();
      rstn = 1'b1;
      step();
      step();
      chk("mr_flushed", b0.valid_o, 0);
      chk("mr_err_after", b0.err_o, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
